// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if
//   Groups the redirect request inputs and the fetch-address / flush outputs
//   of pc_redirect_unit into a single bus.
//   Parameter: CNT_W -- width of TakenCount (must match the unit's CNT_W).
//   master : pipeline side (drives Branch_out/BranchTarget/Jump/JumpTarget/Stall,
//            reads PC/PCPlus4/Flush_IFID/Flush_IDEX/Redirect/TakenCount)
//   slave  : pc_redirect_unit side (directions reversed)
interface pc_redirect_unit_if #(
  parameter int CNT_W = 16
);
  logic              Branch_out;
  logic [31:0]       BranchTarget;
  logic              Jump;
  logic [31:0]       JumpTarget;
  logic              Stall;
  logic [31:0]       PC;
  logic [31:0]       PCPlus4;
  logic              Flush_IFID;
  logic              Flush_IDEX;
  logic              Redirect;
  logic [CNT_W-1:0]  TakenCount;

  modport master (
    output Branch_out, BranchTarget, Jump, JumpTarget, Stall,
    input  PC, PCPlus4, Flush_IFID, Flush_IDEX, Redirect, TakenCount
  );

  modport slave (
    input  Branch_out, BranchTarget, Jump, JumpTarget, Stall,
    output PC, PCPlus4, Flush_IFID, Flush_IDEX, Redirect, TakenCount
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Fetch PC register with branch/jump redirect, flush generation and a
//   saturating count of accepted redirects.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - pc_redirect_unit_if.slave:
//            in : Branch_out, BranchTarget (EX), Jump, JumpTarget (ID), Stall
//            out: PC (registered), PCPlus4 (comb), Flush_IFID/Flush_IDEX (comb),
//                 Redirect (registered, = state REDIR), TakenCount (saturating)
//   Parameters: RESET_PC, CNT_W
//   Build option: define BRANCH_DELAY_SLOT_EN for MIPS delay-slot semantics
//   (taken branch keeps the ID-stage slot, jump keeps the IF-stage slot).
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  pc_redirect_unit_if.slave  bus
);

  typedef enum logic {RUN, REDIR} state_t;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic BR_FLUSH_IDEX = 1'b0;
  localparam logic J_FLUSH_IFID  = 1'b0;
`else
  localparam logic BR_FLUSH_IDEX = 1'b1;
  localparam logic J_FLUSH_IFID  = 1'b1;
`endif

  state_t            state_q, state_n;
  logic [31:0]       pc_q, pc_n, pc_plus4;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              flush_ifid, flush_idex;

  assign pc_plus4 = pc_q + 32'd4;  // wraps naturally at 2^32

  always_comb begin
    state_n    = RUN;
    pc_n       = pc_q;
    accept     = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.Branch_out) begin
          // EX-stage branch wins over everything, stall included
          pc_n       = bus.BranchTarget & ~32'h3;
          accept     = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = BR_FLUSH_IDEX;
          state_n    = REDIR;
        end else if (bus.Jump && !bus.Stall) begin
          pc_n       = bus.JumpTarget & ~32'h3;
          accept     = 1'b1;
          flush_ifid = J_FLUSH_IFID;
          state_n    = REDIR;
        end else if (!bus.Stall) begin
          // a stalled jump is dropped here; ID will present it again
          pc_n = pc_plus4;
        end
      end
      REDIR: begin
        // requests seen now come from squashed bubbles
        if (!bus.Stall) pc_n = pc_plus4;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      if (accept && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

  // flushes are combinational; gate with rst so they stay low during reset
  assign bus.PC         = pc_q;
  assign bus.PCPlus4    = pc_plus4;
  assign bus.Flush_IFID = flush_ifid & ~rst;
  assign bus.Flush_IDEX = flush_idex & ~rst;
  assign bus.Redirect   = (state_q == REDIR);
  assign bus.TakenCount = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic EXP_BR_IDEX = 1'b0;
  localparam logic EXP_J_IFID  = 1'b0;
`else
  localparam logic EXP_BR_IDEX = 1'b1;
  localparam logic EXP_J_IFID  = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  pc_redirect_unit_if #(.CNT_W(16)) bus1();
  pc_redirect_unit_if #(.CNT_W(2))  bus2();

  pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  pc_redirect_unit #(.RESET_PC(32'hFFFF_FFF4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2.slave));

  int n_pass  = 0;
  int n_total = 0;

  // scoreboards: expected values queued when stimulus is applied
  logic [31:0] exp_pc_q[$];
  logic [1:0]  exp_cnt_q[$];
  logic [31:0] e_pc;
  logic [1:0]  e_cnt;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    bus1.Branch_out = 1'b1; bus1.BranchTarget = 32'h80;
    bus1.Jump = 1'b0; bus1.JumpTarget = 32'h0; bus1.Stall = 1'b0;
    bus2.Branch_out = 1'b0; bus2.BranchTarget = 32'h0;
    bus2.Jump = 1'b0; bus2.JumpTarget = 32'h0; bus2.Stall = 1'b0;
    #2;
    n_total++; if (bus1.PC !== 32'h0) $display("FAIL rst_pc got %h exp %h", bus1.PC, 32'h0); else n_pass++;
    n_total++; if (bus1.Redirect !== 1'b0) $display("FAIL rst_redirect got %b exp 0", bus1.Redirect); else n_pass++;
    n_total++; if (bus1.TakenCount !== 16'd0) $display("FAIL rst_count got %0d exp 0", bus1.TakenCount); else n_pass++;
    n_total++; if ({bus1.Flush_IFID, bus1.Flush_IDEX} !== 2'b00) $display("FAIL rst_flush got %b exp 00", {bus1.Flush_IFID, bus1.Flush_IDEX}); else n_pass++;
    tick(); tick();
    n_total++; if (bus1.PC !== 32'h0 || bus1.Redirect !== 1'b0) $display("FAIL rst_hold_with_branch got pc=%h red=%b exp pc=0 red=0", bus1.PC, bus1.Redirect); else n_pass++;
    bus1.Branch_out = 1'b0;
    rst = 1'b0;
    n_total++; if (bus1.PC !== 32'h0) $display("FAIL release_pc got %h exp 0", bus1.PC); else n_pass++;
    exp_pc_q.push_back(32'h4); exp_pc_q.push_back(32'h8); exp_pc_q.push_back(32'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      e_pc = exp_pc_q.pop_front();
      n_total++; if (bus1.PC !== e_pc) $display("FAIL seq_pc%0d got %h exp %h", i, bus1.PC, e_pc); else n_pass++;
    end
    n_total++; if (bus1.TakenCount !== 16'd0) $display("FAIL seq_count got %0d exp 0", bus1.TakenCount); else n_pass++;
  endtask

  task automatic test_branch();
    tick();
    n_total++; if (bus1.PC !== 32'h10) $display("FAIL pc_0x10 got %h exp 10", bus1.PC); else n_pass++;
    n_total++; if (bus1.PCPlus4 !== 32'h14) $display("FAIL pcplus4 got %h exp 14", bus1.PCPlus4); else n_pass++;
    bus1.Branch_out = 1'b1; bus1.BranchTarget = 32'h103;
    #1;
    n_total++; if (bus1.Flush_IFID !== 1'b1) $display("FAIL br_flush_ifid got %b exp 1", bus1.Flush_IFID); else n_pass++;
    n_total++; if (bus1.Flush_IDEX !== EXP_BR_IDEX) $display("FAIL br_flush_idex got %b exp %b", bus1.Flush_IDEX, EXP_BR_IDEX); else n_pass++;
    tick();
    n_total++; if (bus1.PC !== 32'h100) $display("FAIL br_target got %h exp 100", bus1.PC); else n_pass++;
    n_total++; if (bus1.Redirect !== 1'b1) $display("FAIL br_redirect got %b exp 1", bus1.Redirect); else n_pass++;
    n_total++; if (bus1.TakenCount !== 16'd1) $display("FAIL br_count got %0d exp 1", bus1.TakenCount); else n_pass++;
    bus1.Branch_out = 1'b0;
    #1;
    n_total++; if ({bus1.Flush_IFID, bus1.Flush_IDEX} !== 2'b00) $display("FAIL redir_flush got %b exp 00", {bus1.Flush_IFID, bus1.Flush_IDEX}); else n_pass++;
    tick();
    n_total++; if (bus1.PC !== 32'h104 || bus1.Redirect !== 1'b0) $display("FAIL br_after got pc=%h red=%b exp pc=104 red=0", bus1.PC, bus1.Redirect); else n_pass++;
  endtask

  task automatic test_jump_stall();
    bus1.Jump = 1'b1; bus1.JumpTarget = 32'h200; bus1.Stall = 1'b1;
    #1;
    n_total++; if ({bus1.Flush_IFID, bus1.Flush_IDEX} !== 2'b00) $display("FAIL jstall_flush got %b exp 00", {bus1.Flush_IFID, bus1.Flush_IDEX}); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++; if (bus1.PC !== 32'h104 || bus1.Redirect !== 1'b0) $display("FAIL jstall_hold%0d got pc=%h red=%b exp pc=104 red=0", i, bus1.PC, bus1.Redirect); else n_pass++;
    end
    bus1.Stall = 1'b0;
    #1;
    n_total++; if (bus1.Flush_IFID !== EXP_J_IFID) $display("FAIL j_flush_ifid got %b exp %b", bus1.Flush_IFID, EXP_J_IFID); else n_pass++;
    n_total++; if (bus1.Flush_IDEX !== 1'b0) $display("FAIL j_flush_idex got %b exp 0", bus1.Flush_IDEX); else n_pass++;
    tick();
    n_total++; if (bus1.PC !== 32'h200 || bus1.Redirect !== 1'b1) $display("FAIL j_target got pc=%h red=%b exp pc=200 red=1", bus1.PC, bus1.Redirect); else n_pass++;
    n_total++; if (bus1.TakenCount !== 16'd2) $display("FAIL j_count got %0d exp 2", bus1.TakenCount); else n_pass++;
    bus1.Jump = 1'b0;
  endtask

  task automatic test_priority();
    // stall while in REDIR: PC held, still leaves REDIR
    bus1.Stall = 1'b1;
    tick();
    n_total++; if (bus1.PC !== 32'h200 || bus1.Redirect !== 1'b0) $display("FAIL redir_stall got pc=%h red=%b exp pc=200 red=0", bus1.PC, bus1.Redirect); else n_pass++;
    bus1.Stall = 1'b0;
    bus1.Branch_out = 1'b1; bus1.BranchTarget = 32'h300;
    bus1.Jump = 1'b1; bus1.JumpTarget = 32'h400;
    #1;
    n_total++; if (bus1.Flush_IDEX !== EXP_BR_IDEX) $display("FAIL prio_flush_idex got %b exp %b", bus1.Flush_IDEX, EXP_BR_IDEX); else n_pass++;
    tick();
    n_total++; if (bus1.PC !== 32'h300) $display("FAIL prio_target got %h exp 300", bus1.PC); else n_pass++;
    bus1.BranchTarget = 32'h500; bus1.JumpTarget = 32'h600;
    #1;
    n_total++; if ({bus1.Flush_IFID, bus1.Flush_IDEX} !== 2'b00) $display("FAIL prio_redir_flush got %b exp 00", {bus1.Flush_IFID, bus1.Flush_IDEX}); else n_pass++;
    tick();
    n_total++; if (bus1.PC !== 32'h304 || bus1.Redirect !== 1'b0) $display("FAIL prio_ignored got pc=%h red=%b exp pc=304 red=0", bus1.PC, bus1.Redirect); else n_pass++;
    n_total++; if (bus1.TakenCount !== 16'd3) $display("FAIL prio_count got %0d exp 3", bus1.TakenCount); else n_pass++;
    bus1.Branch_out = 1'b0; bus1.Jump = 1'b0;
  endtask

  task automatic test_reset_mid_redir();
    bus1.Branch_out = 1'b1; bus1.BranchTarget = 32'h700;
    tick();
    n_total++; if (bus1.PC !== 32'h700 || bus1.Redirect !== 1'b1) $display("FAIL pre_rst got pc=%h red=%b exp pc=700 red=1", bus1.PC, bus1.Redirect); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus1.PC !== 32'h0 || bus1.Redirect !== 1'b0) $display("FAIL async_rst got pc=%h red=%b exp pc=0 red=0", bus1.PC, bus1.Redirect); else n_pass++;
    n_total++; if (bus1.TakenCount !== 16'd0 || bus1.Flush_IFID !== 1'b0) $display("FAIL async_rst_cnt got cnt=%0d fl=%b exp cnt=0 fl=0", bus1.TakenCount, bus1.Flush_IFID); else n_pass++;
    tick();
    bus1.Branch_out = 1'b0;
    rst = 1'b0;
    n_total++; if (bus1.PC !== 32'h0) $display("FAIL rst_release_pc got %h exp 0", bus1.PC); else n_pass++;
    exp_pc_q.push_back(32'h4); exp_pc_q.push_back(32'h8);
    for (int i = 0; i < 2; i++) begin
      tick();
      e_pc = exp_pc_q.pop_front();
      n_total++; if (bus1.PC !== e_pc) $display("FAIL post_rst_pc%0d got %h exp %h", i, bus1.PC, e_pc); else n_pass++;
    end
  endtask

  task automatic test_saturate();
    n_total++; if (bus2.PC !== 32'hFFFF_FFF4) $display("FAIL sat_rst_pc got %h exp fffffff4", bus2.PC); else n_pass++;
    rst2 = 1'b0;
    tick(); tick();
    n_total++; if (bus2.PC !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h exp fffffffc", bus2.PC); else n_pass++;
    n_total++; if (bus2.PCPlus4 !== 32'h0) $display("FAIL wrap_pcplus4 got %h exp 0", bus2.PCPlus4); else n_pass++;
    tick();
    n_total++; if (bus2.PC !== 32'h0) $display("FAIL wrap_next got %h exp 0", bus2.PC); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      bus2.Branch_out = 1'b1; bus2.BranchTarget = 32'h40 * (i + 1);
      exp_pc_q.push_back(32'h40 * (i + 1));
      exp_cnt_q.push_back((i + 1 > 3) ? 2'd3 : 2'(i + 1));
      tick();
      e_pc = exp_pc_q.pop_front();
      e_cnt = exp_cnt_q.pop_front();
      n_total++; if (bus2.PC !== e_pc) $display("FAIL sat_pc%0d got %h exp %h", i, bus2.PC, e_pc); else n_pass++;
      n_total++; if (bus2.TakenCount !== e_cnt) $display("FAIL sat_cnt%0d got %0d exp %0d", i, bus2.TakenCount, e_cnt); else n_pass++;
      bus2.Branch_out = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump_stall();
    test_priority();
    test_reset_mid_redir();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
